// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad event SPI transmitter.
package keypad_pkg;

    typedef logic [3:0] key_t;

    localparam int FRAME_W = 8;
    localparam logic [FRAME_W-1:0] CLEAR_CMD_DEFAULT = 8'hC1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } frame_state_t;

endpackage

// File: rtl/keypad_spi_tx_key_fifo.sv
// Small circular FIFO of key codes; flush takes priority over push and pop.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          slowclk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [3:0]    din,
    output logic [3:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    key_t          mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 4'h0;
            end
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[tail_r] <= din;
                tail_r        <= tail_r + AW'(1);
            end
            if (pop) begin
                head_r <= head_r + AW'(1);
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem_r[head_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/keypad_spi_tx.sv
// Buffers scanner key events and returns one per SPI chip-select frame (mode 0,
// MSB first). All SPI pins are synchronised into slowclk and edge-detected.
module keypad_spi_tx
    import keypad_pkg::*;
#(
    parameter int                 DEPTH       = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [FRAME_W-1:0] CLEAR_CMD   = CLEAR_CMD_DEFAULT
) (
    input  logic                     slowclk,
    input  logic                     reset,
    input  logic [3:0]               key_code,
    input  logic                     key_valid,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_active
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int BCW = $clog2(FRAME_W) + 1;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d_r;
    logic                   cs_d_r;

    logic sclk_now_s, cs_now_s, mosi_now_s;
    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

    frame_state_t         state_r, state_next;
    logic [FRAME_W-1:0]   tx_sr_r, rx_sr_r, tx_next_s, tx_load_s;
    logic [BCW-1:0]       bit_cnt_r;
    logic                 miso_r, miso_next_s;
    logic                 overflow_r, ovf_reported_r, frame_active_r;

    logic load_s, pop_s, rx_shift_s, tx_shift_s, close_s;
    logic flush_s, push_s, drop_s, clear_ovf_s;

    logic [3:0]    fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s, fifo_empty_s;

    // Pin synchronisers plus one extra stage per edge-detected input.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
            cs_d_r      <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
            cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_now_s  = sclk_sync_r[SYNC_STAGES-1];
    assign cs_now_s    = cs_sync_r[SYNC_STAGES-1];
    assign mosi_now_s  = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_now_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_now_s & sclk_d_r;
    assign cs_rise_s   = cs_now_s & ~cs_d_r;
    assign cs_fall_s   = ~cs_now_s & cs_d_r;

    // Frame sequencing: next state and per-cycle datapath strobes.
    always_comb begin
        state_next = state_r;
        load_s     = 1'b0;
        pop_s      = 1'b0;
        rx_shift_s = 1'b0;
        tx_shift_s = 1'b0;
        close_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The head is consumed even if the frame is aborted here.
                load_s = 1'b1;
                pop_s  = ~fifo_empty_s;
                if (cs_rise_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_next = ST_IDLE;
                end else begin
                    rx_shift_s = sclk_rise_s;
                    tx_shift_s = sclk_fall_s;
                    if (sclk_rise_s && (bit_cnt_r == BCW'(FRAME_W - 1))) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                tx_shift_s = sclk_fall_s;
                if (cs_rise_s) begin
                    close_s    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign flush_s     = close_s & (rx_sr_r == CLEAR_CMD);
    assign push_s      = key_valid & ~flush_s & (~fifo_full_s | pop_s);
    assign drop_s      = key_valid & ~flush_s & fifo_full_s & ~pop_s;
    assign clear_ovf_s = close_s & ovf_reported_r;

    // Transmit shifter next value and the registered miso it drives.
    always_comb begin
        tx_next_s   = tx_sr_r;
        miso_next_s = 1'b0;
        if (fifo_empty_s) begin
            tx_load_s = {1'b0, overflow_r, 2'b00, 4'h0};
        end else begin
            tx_load_s = {1'b1, overflow_r, 2'b00, fifo_head_s};
        end
        if (load_s) begin
            tx_next_s = tx_load_s;
        end else if (tx_shift_s) begin
            tx_next_s = {tx_sr_r[FRAME_W-2:0], 1'b0};
        end else begin
            tx_next_s = tx_sr_r;
        end
        if (state_next == ST_IDLE) begin
            miso_next_s = 1'b0;
        end else begin
            miso_next_s = tx_next_s[FRAME_W-1];
        end
    end

    // Frame state, shift registers and status flags.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            tx_sr_r        <= {FRAME_W{1'b0}};
            rx_sr_r        <= {FRAME_W{1'b0}};
            bit_cnt_r      <= {BCW{1'b0}};
            miso_r         <= 1'b0;
            overflow_r     <= 1'b0;
            ovf_reported_r <= 1'b0;
            frame_active_r <= 1'b0;
        end else begin
            state_r        <= state_next;
            tx_sr_r        <= tx_next_s;
            miso_r         <= miso_next_s;
            frame_active_r <= (state_next == ST_SHIFT) || (state_next == ST_DONE);
            if (load_s) begin
                rx_sr_r        <= {FRAME_W{1'b0}};
                bit_cnt_r      <= {BCW{1'b0}};
                ovf_reported_r <= overflow_r;
            end else if (rx_shift_s) begin
                rx_sr_r   <= {rx_sr_r[FRAME_W-2:0], mosi_now_s};
                bit_cnt_r <= bit_cnt_r + BCW'(1);
            end
            // A drop in the closing cycle outranks clearing the reported flag.
            if (flush_s) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_ovf_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    key_fifo #(
        .DEPTH (DEPTH)
    ) u_key_fifo (
        .slowclk (slowclk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .din     (key_code),
        .dout    (fifo_head_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign miso         = miso_r;
    assign fifo_count   = fifo_count_s;
    assign overflow     = overflow_r;
    assign frame_active = frame_active_r;

endmodule

// File: tb/tb_keypad_spi_tx.sv
// Scoreboard bench for keypad_spi_tx: a queue-based event model predicts each
// frame byte; a monitor assembles miso bits on sclk rises and compares at cs_n rise.
module tb_keypad_spi_tx;

    localparam int DEPTH = 4;

    logic       slowclk = 1'b0;
    logic       reset;
    logic [3:0] key_code;
    logic       key_valid;
    logic       sclk;
    logic       cs_n = 1'b1;
    logic       mosi;
    logic       miso;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       frame_active;

    int checks = 0;
    int errors = 0;

    logic [3:0] mq[$];
    logic       m_ovf;
    logic [7:0] exp_q[$];

    keypad_spi_tx #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2),
        .CLEAR_CMD   (8'hC1)
    ) dut (
        .slowclk      (slowclk),
        .reset        (reset),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .frame_active (frame_active)
    );

    always #5 slowclk = ~slowclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge slowclk);
    endtask

    task automatic model_push(input logic [3:0] k);
        if (mq.size() < DEPTH) mq.push_back(k);
        else m_ovf = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, " fifo_count"}, fifo_count, mq.size());
        check({tag, " overflow"}, overflow, m_ovf);
    endtask

    task automatic push_key(input logic [3:0] k);
        @(negedge slowclk);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge slowclk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_push(k);
        wait_cyc(1);
    endtask

    // One chip-select frame; nbits < 8 aborts early. Optionally pulses key_valid
    // in the DUT's load cycle (pin edge + 4 clocks).
    task automatic run_frame(input logic [7:0] tx, input int nbits, input bit load_push,
                             input logic [3:0] lp_key, input string tag);
        logic [7:0] eb;
        logic       reported;
        reported = m_ovf;
        if (mq.size() == 0) eb = {1'b0, m_ovf, 6'd0};
        else eb = {1'b1, m_ovf, 2'b00, mq.pop_front()};
        if (nbits == 8) exp_q.push_back(eb);
        if (load_push) model_push(lp_key);
        @(negedge slowclk);
        cs_n = 1'b0;
        wait_cyc(3);
        if (load_push) begin
            key_code  = lp_key;
            key_valid = 1'b1;
        end
        wait_cyc(1);
        key_valid = 1'b0;
        wait_cyc(2);
        check({tag, " frame_active_in"}, frame_active, 1);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_cyc(6);
            sclk = 1'b1;
            wait_cyc(6);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        wait_cyc(6);
        cs_n = 1'b1;
        wait_cyc(8);
        if (nbits == 8) begin
            if (reported) m_ovf = 1'b0;
            if (tx == 8'hC1) begin
                mq.delete();
                m_ovf = 1'b0;
            end
        end
        check({tag, " frame_active_out"}, frame_active, 0);
        check_status(tag);
    endtask

    // Monitor: collect miso on each sclk rise inside a frame, compare complete frames.
    initial begin : monitor
        logic [7:0] sh;
        logic [7:0] e;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n === 1'b1) begin
                if (nb == 8) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_byte actual=%0h expected=none", sh);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", sh, e);
                    end
                end
                nb = 0;
                sh = 8'h00;
            end else begin
                sh = {sh[6:0], miso};
                nb++;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        int r;
        logic [7:0] tb;
        int nb;
        reset     = 1'b1;
        key_code  = 4'h0;
        key_valid = 1'b0;
        sclk      = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        m_ovf     = 1'b0;
        wait_cyc(3);
        check("reset miso", miso, 0);
        check("reset frame_active", frame_active, 0);
        check_status("reset");
        reset = 1'b0;
        wait_cyc(2);

        run_frame(8'h00, 8, 1'b0, 4'h0, "empty");

        push_key(4'hA);
        check_status("push_a");
        run_frame(8'h00, 8, 1'b0, 4'h0, "key_a");

        for (int k = 1; k <= 5; k++) push_key(4'(k));
        check_status("overfill");
        for (int f = 0; f < 5; f++) run_frame(8'h00, 8, 1'b0, 4'h0, "drain");

        push_key(4'h7);
        push_key(4'h8);
        push_key(4'h9);
        run_frame(8'hC1, 8, 1'b0, 4'h0, "clear_cmd");

        push_key(4'hB);
        push_key(4'hC);
        run_frame(8'h00, 3, 1'b0, 4'h0, "abort");
        run_frame(8'h00, 8, 1'b0, 4'h0, "after_abort");

        for (int k = 1; k <= 4; k++) push_key(4'(k));
        run_frame(8'h00, 8, 1'b1, 4'hD, "load_push");
        for (int f = 0; f < 4; f++) run_frame(8'h00, 8, 1'b0, 4'h0, "load_drain");

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 2);
            if (r < 2) begin
                push_key(4'($urandom_range(0, 15)));
                check_status("rand_push");
            end else begin
                tb = ($urandom_range(0, 4) == 0) ? 8'hC1 : 8'($urandom_range(0, 255));
                nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
                run_frame(tb, nb, 1'b0, 4'h0, "rand_frame");
            end
        end

        // Reset while shifting out 0x8F: after four falls miso carries bit 3 (1).
        run_frame(8'h00, 8, 1'b0, 4'h0, "pre_flush");
        while (mq.size() > 0) run_frame(8'h00, 8, 1'b0, 4'h0, "pre_empty");
        push_key(4'hF);
        push_key(4'h5);
        @(negedge slowclk);
        cs_n = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(6);
            sclk = 1'b1;
            wait_cyc(6);
            sclk = 1'b0;
        end
        wait_cyc(5);
        check("mid_shift miso", miso, 1);
        reset = 1'b1;
        #1;
        check("mid_reset miso", miso, 0);
        check("mid_reset fifo_count", fifo_count, 0);
        check("mid_reset frame_active", frame_active, 0);
        mq.delete();
        m_ovf = 1'b0;
        wait_cyc(2);
        cs_n = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(4);
        run_frame(8'h00, 8, 1'b0, 4'h0, "post_reset");

        wait_cyc(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
